jr_hazard_sequencer: RTL and testbench

//  Sequences JR (jump-register) resolution in the ID stage of the 5-stage pipeline.

---
 rtl/jr_hazard_sequencer_pkg.sv | 18 +
 rtl/jr_hazard_sequencer_fwd_select.sv | 38 +++
 rtl/jr_hazard_sequencer.sv | 154 +++++++++++++++
 tb/tb_jr_hazard_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jr_hazard_sequencer_pkg.sv
// Shared definitions for JR resolution in the ID stage: FSM state encoding,
// forward-select codes and the hardwired-zero register index.
package jr_hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LDWAIT = 2'd1,
        ST_SQUASH = 2'd2
    } jr_state_e;

    localparam logic [1:0] JR_FWD_RF  = 2'b00;
    localparam logic [1:0] JR_FWD_EX  = 2'b01;
    localparam logic [1:0] JR_FWD_MEM = 2'b10;
    localparam logic [1:0] JR_FWD_LD  = 2'b11;

    localparam int REG_ZERO = 0;

endpackage : jr_hazard_sequencer_pkg

// File: rtl/jr_hazard_sequencer_fwd_select.sv
// Combinational JR source hit detection and forward priority (EX over MEM).
// load_use flags a source produced by a load that is still in EX.
module jr_fwd_select
    import jr_hazard_sequencer_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_we,
    input  logic              ex_mem_re,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_we,
    input  logic              mem_mem_re,
    output logic [1:0]        fwd_sel,
    output logic              load_use
);

    logic src_nz;
    logic hit_ex;
    logic hit_mem;

    // r0 is hardwired zero, so a write to it never produces a forwardable value.
    assign src_nz  = (src != REG_AW'(REG_ZERO));
    assign hit_ex  = src_nz && (src == ex_dst) && ex_we;
    assign hit_mem = src_nz && (src == mem_dst) && mem_we;

    always_comb begin
        fwd_sel  = JR_FWD_RF;
        load_use = hit_ex && ex_mem_re;
        if (hit_ex && !ex_mem_re) begin
            fwd_sel = JR_FWD_EX;
        end else if (!hit_ex && hit_mem) begin
            fwd_sel = mem_mem_re ? JR_FWD_LD : JR_FWD_MEM;
        end
    end

endmodule : jr_fwd_select

// File: rtl/jr_hazard_sequencer.sv
// JR resolution sequencer: picks the JR operand source, takes a one-cycle
// load-use stall when needed, redirects the PC, squashes the wrong-path fetch.
module jr_hazard_sequencer
    import jr_hazard_sequencer_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stall,
    input  logic              ID_jr_valid,
    input  logic [REG_AW-1:0] ID_jr_src,
    input  logic [REG_AW-1:0] EX_dst,
    input  logic              EX_we,
    input  logic              EX_mem_re,
    input  logic [REG_AW-1:0] MEM_dst,
    input  logic              MEM_we,
    input  logic              MEM_mem_re,
    output logic [1:0]        jr_fwd_sel,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              pc_redirect,
    output logic              flush_if,
    output logic              busy,
    output logic [CNT_W-1:0]  jr_count,
    output logic [CNT_W-1:0]  jr_stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    jr_state_e         state_q, state_d;
    logic [REG_AW-1:0] src_q, src_d;
    logic [CNT_W-1:0]  jr_cnt_q, jr_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [REG_AW-1:0] cur_src;
    logic [1:0]        sel;
    logic              load_use;
    logic              inc_jr;
    logic              inc_stall;

    logic [1:0]        fwd_sel_c;
    logic              stall_c;
    logic              bubble_c;
    logic              redirect_c;
    logic              flush_c;

    // In LDWAIT the captured source is re-evaluated so a younger EX writer still wins.
    assign cur_src = (state_q == ST_IDLE) ? ID_jr_src : src_q;

    jr_fwd_select #(
        .REG_AW (REG_AW)
    ) u_fwd_select (
        .src        (cur_src),
        .ex_dst     (EX_dst),
        .ex_we      (EX_we),
        .ex_mem_re  (EX_mem_re),
        .mem_dst    (MEM_dst),
        .mem_we     (MEM_we),
        .mem_mem_re (MEM_mem_re),
        .fwd_sel    (sel),
        .load_use   (load_use)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        inc_jr     = 1'b0;
        inc_stall  = 1'b0;
        fwd_sel_c  = JR_FWD_RF;
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        redirect_c = 1'b0;
        flush_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ID_jr_valid) begin
                    if (load_use) begin
                        // Stall/bubble stay asserted through a freeze; only the transition waits.
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                        if (!ext_stall) begin
                            src_d     = ID_jr_src;
                            inc_stall = 1'b1;
                            state_d   = ST_LDWAIT;
                        end
                    end else if (!ext_stall) begin
                        redirect_c = 1'b1;
                        flush_c    = 1'b1;
                        fwd_sel_c  = sel;
                        inc_jr     = 1'b1;
                        state_d    = ST_SQUASH;
                    end
                end
            end
            ST_LDWAIT: begin
                if (!ext_stall) begin
                    redirect_c = 1'b1;
                    flush_c    = 1'b1;
                    fwd_sel_c  = sel;
                    inc_jr     = 1'b1;
                    state_d    = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                // The IF/ID slot holds the flushed wrong-path instruction; ignore its JR.
                if (!ext_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        jr_cnt_d    = jr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (inc_jr && (jr_cnt_q != CNT_MAX)) begin
            jr_cnt_d = jr_cnt_q + CNT_W'(1);
        end
        if (inc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            jr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            jr_cnt_q    <= jr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset quiets every output at once, before the first edge clears the registers.
    assign jr_fwd_sel     = rst ? JR_FWD_RF : fwd_sel_c;
    assign stall_if_id    = !rst && stall_c;
    assign bubble_ex      = !rst && bubble_c;
    assign pc_redirect    = !rst && redirect_c;
    assign flush_if       = !rst && flush_c;
    assign busy           = !rst && (state_q != ST_IDLE);
    assign jr_count       = rst ? '0 : jr_cnt_q;
    assign jr_stall_count = rst ? '0 : stall_cnt_q;

endmodule : jr_hazard_sequencer

// File: tb/tb_jr_hazard_sequencer.sv
// Directed and random stimulus for jr_hazard_sequencer, checked against a
// behavioural model of the JR resolution rules.
module tb_jr_hazard_sequencer;

    localparam int REG_AW  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // clock / reset and DUT signals
    logic clk = 1'b0;
    logic rst;
    logic ext_stall;
    logic id_valid;
    logic [REG_AW-1:0] id_src, ex_dst, mem_dst;
    logic ex_we, ex_re, mem_we, mem_re;
    logic [1:0] jr_fwd_sel;
    logic stall_if_id, bubble_ex, pc_redirect, flush_if, busy;
    logic [CNT_W-1:0] jr_count, jr_stall_count;

    always #5 clk = ~clk;

    jr_hazard_sequencer #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_stall      (ext_stall),
        .ID_jr_valid    (id_valid),
        .ID_jr_src      (id_src),
        .EX_dst         (ex_dst),
        .EX_we          (ex_we),
        .EX_mem_re      (ex_re),
        .MEM_dst        (mem_dst),
        .MEM_we         (mem_we),
        .MEM_mem_re     (mem_re),
        .jr_fwd_sel     (jr_fwd_sel),
        .stall_if_id    (stall_if_id),
        .bubble_ex      (bubble_ex),
        .pc_redirect    (pc_redirect),
        .flush_if       (flush_if),
        .busy           (busy),
        .jr_count       (jr_count),
        .jr_stall_count (jr_stall_count)
    );

    int errors = 0;
    int checks = 0;

    // reference model: 0 = free, 1 = waiting for load to reach MEM, 2 = shadow slot
    int m_mode, m_src, m_jr, m_st;
    int n_mode, n_src, n_jr, n_st;
    int e_sel, e_stall, e_bub, e_red, e_fl, e_busy, e_jr, e_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_in(input int v, input int s, input int ed, input int ewe, input int ere,
                          input int md, input int mwe, input int mre);
        id_valid = v[0];
        id_src   = REG_AW'(s);
        ex_dst   = REG_AW'(ed);
        ex_we    = ewe[0];
        ex_re    = ere[0];
        mem_dst  = REG_AW'(md);
        mem_we   = mwe[0];
        mem_re   = mre[0];
    endtask

    task automatic model_eval();
        int s;
        bit hex, hmem;
        int sel;
        e_sel = 0; e_stall = 0; e_bub = 0; e_red = 0; e_fl = 0;
        e_busy = 0; e_jr = 0; e_st = 0;
        n_mode = m_mode; n_src = m_src; n_jr = m_jr; n_st = m_st;
        if (rst) begin
            n_mode = 0; n_src = 0; n_jr = 0; n_st = 0;
        end else begin
            e_busy = (m_mode != 0);
            e_jr   = m_jr;
            e_st   = m_st;
            s    = (m_mode == 0) ? int'(id_src) : m_src;
            hex  = (s != 0) && (s == int'(ex_dst)) && ex_we;
            hmem = (s != 0) && (s == int'(mem_dst)) && mem_we;
            if (hex && !ex_re) sel = 1;
            else if (!hex && hmem) sel = mem_re ? 3 : 2;
            else sel = 0;
            if (m_mode == 0 && id_valid && hex && ex_re) begin
                e_stall = 1;
                e_bub   = 1;
                if (!ext_stall) begin
                    n_mode = 1;
                    n_src  = s;
                    if (m_st < CNT_MAX) n_st = m_st + 1;
                end
            end else if ((m_mode == 0 && id_valid) || m_mode == 1) begin
                if (!ext_stall) begin
                    e_red = 1;
                    e_fl  = 1;
                    e_sel = sel;
                    if (m_jr < CNT_MAX) n_jr = m_jr + 1;
                    n_mode = 2;
                end
            end else if (m_mode == 2 && !ext_stall) begin
                n_mode = 0;
            end
        end
    endtask

    // compare all outputs at the falling edge, away from the active edge
    task automatic sample();
        @(negedge clk);
        model_eval();
        chk("fwd_sel", 32'(jr_fwd_sel), e_sel);
        chk("stall_if_id", 32'(stall_if_id), e_stall);
        chk("bubble_ex", 32'(bubble_ex), e_bub);
        chk("pc_redirect", 32'(pc_redirect), e_red);
        chk("flush_if", 32'(flush_if), e_fl);
        chk("busy", 32'(busy), e_busy);
        chk("jr_count", 32'(jr_count), e_jr);
        chk("jr_stall_count", 32'(jr_stall_count), e_st);
    endtask

    task automatic tick();
        m_mode = n_mode; m_src = n_src; m_jr = n_jr; m_st = n_st;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        tick();
    endtask

    initial begin
        m_mode = 0; m_src = 0; m_jr = 0; m_st = 0;
        rst = 1'b1;
        ext_stall = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // 1: plain JR from the regfile, same-cycle redirect
        set_in(1, 5, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t1_sel", 32'(jr_fwd_sel), 0);
        chk("t1_redirect", 32'(pc_redirect), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        sample();
        chk("t1_jr_count", 32'(jr_count), 1);
        tick();

        // 2: EX and MEM both write r3; EX wins
        set_in(1, 3, 3, 1, 0, 3, 1, 0);
        sample();
        chk("t2_sel", 32'(jr_fwd_sel), 1);
        chk("t2_stall", 32'(stall_if_id), 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // 3: load r4 in EX -> one stall, then redirect from load data
        set_in(1, 4, 4, 1, 1, 0, 0, 0);
        sample();
        chk("t3_stall", 32'(stall_if_id), 1);
        tick();
        set_in(1, 4, 0, 0, 0, 4, 1, 1);
        sample();
        chk("t3_busy", 32'(busy), 1);
        chk("t3_sel", 32'(jr_fwd_sel), 3);
        chk("t3_redirect", 32'(pc_redirect), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t3_stall_count", 32'(jr_stall_count), 1);
        tick();

        // 4: JR r0 never forwards; valid held through the squash slot
        set_in(1, 0, 0, 1, 1, 0, 1, 1);
        sample();
        chk("t4_sel", 32'(jr_fwd_sel), 0);
        chk("t4_stall", 32'(stall_if_id), 0);
        tick();
        sample();
        chk("t4_squash_redirect", 32'(pc_redirect), 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // 5: freeze while waiting on a load
        set_in(1, 4, 4, 1, 1, 0, 0, 0);
        cyc();
        ext_stall = 1'b1;
        set_in(0, 0, 0, 0, 0, 4, 1, 1);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t5_frozen_redirect", 32'(pc_redirect), 0);
            tick();
        end
        ext_stall = 1'b0;
        sample();
        chk("t5_sel", 32'(jr_fwd_sel), 3);
        chk("t5_redirect", 32'(pc_redirect), 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // 6: counter saturation, then reset out of LDWAIT
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            set_in(1, 1, 0, 0, 0, 0, 0, 0);
            cyc();
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        sample();
        chk("t6_saturated", 32'(jr_count), CNT_MAX);
        tick();
        set_in(1, 6, 6, 1, 1, 0, 0, 0);
        cyc();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 6, 1, 1);
        sample();
        chk("t6_rst_redirect", 32'(pc_redirect), 0);
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_jr_count", 32'(jr_count), 0);
        tick();

        // random phase: small register numbers so hits are frequent
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            ext_stall = ($urandom_range(0, 5) == 0);
            set_in($urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_jr_hazard_sequencer
